// File: rtl/blackjack_pkg.sv
// Shared blackjack types and constants.
// Holds the card/hand widths, ace values, deck geometry, the dealer FSM state
// enum and the deck-index -> blackjack value map used by card_dealer.
package blackjack_pkg;

    localparam int unsigned CARD_W    = 4;
    localparam int unsigned HAND_W    = 5;
    localparam int unsigned ACE_LOW   = 1;
    localparam int unsigned ACE_HIGH  = 11;
    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned RANKS     = 13;

    typedef logic [CARD_W-1:0] card_t;
    typedef logic [HAND_W-1:0] hand_t;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DELIVER
    } state_t;

    // Rank = idx % 13: rank 0 is the ace (low value), ranks 1..8 are 2..9,
    // ranks 9..12 are ten and the three face cards.
    function automatic card_t card_value(input logic [5:0] idx);
        logic [5:0] rank;
        card_t      value;
        rank = idx % 6'(RANKS);
        if (rank == 6'd0) begin
            value = card_t'(ACE_LOW);
        end else if (rank <= 6'd8) begin
            value = card_t'(rank + 6'd1);
        end else begin
            value = card_t'(10);
        end
        return value;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/deal bus between the requesters (game controller, hand controllers)
// and card_dealer. Signal prefixes are from the dealer's point of view.
//   i_shuffle        restore full deck (priority over everything)
//   i_dealReq        request one card
//   i_dealTarget     0 = player, 1 = dealer
//   o_newCard        value of last dealt card (1..10)
//   o_addPlayer      one-cycle add pulse to the player hand
//   o_addDealer      one-cycle add pulse to the dealer hand
//   o_busy           dealer not idle
//   o_cardsRemaining undealt count 0..52
//   o_deckEmpty      o_cardsRemaining == 0
//   o_reqDropped     one-cycle pulse for a request on an empty deck
interface card_dealer_if;
    import blackjack_pkg::*;

    logic       i_shuffle;
    logic       i_dealReq;
    logic       i_dealTarget;
    card_t      o_newCard;
    logic       o_addPlayer;
    logic       o_addDealer;
    logic       o_busy;
    logic [5:0] o_cardsRemaining;
    logic       o_deckEmpty;
    logic       o_reqDropped;

    modport master (
        output i_shuffle,
        output i_dealReq,
        output i_dealTarget,
        input  o_newCard,
        input  o_addPlayer,
        input  o_addDealer,
        input  o_busy,
        input  o_cardsRemaining,
        input  o_deckEmpty,
        input  o_reqDropped
    );

    modport slave (
        input  i_shuffle,
        input  i_dealReq,
        input  i_dealTarget,
        output o_newCard,
        output o_addPlayer,
        output o_addDealer,
        output o_busy,
        output o_cardsRemaining,
        output o_deckEmpty,
        output o_reqDropped
    );

endinterface

// File: rtl/card_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1,
// shifting right with the feedback entering bit 15.
//   i_clk    clock
//   i_reset  asynchronous active-high reset, loads SEED
//   o_rand   low six bits of the current state (deck index source)
module card_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [5:0] o_rand
);

    // An all-zero state would lock the register, so a zero seed is replaced.
    localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lfsr_q <= SEED_INIT;
        end else begin
            lfsr_q <= {feedback, lfsr_q[15:1]};
        end
    end

    assign o_rand = lfsr_q[5:0];

endmodule

// File: rtl/card_dealer.sv
// Single-deck card source without replacement. A request picks a pseudo-random
// start index from the LFSR, probes forward through the used-card mask until
// it finds an undealt card, then pulses the add input of the selected hand for
// one cycle with the card's blackjack value on o_newCard.
//   i_clk    clock
//   i_reset  asynchronous active-high reset
//   bus      card_dealer_if.slave (request, shuffle, deal outputs, status)
module card_dealer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned DECK_SIZE = 52
) (
    input  logic          i_clk,
    input  logic          i_reset,
    card_dealer_if.slave  bus
);
    import blackjack_pkg::*;

    localparam logic [5:0] DECK_CNT = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

    state_t                 state_q;
    logic [DECK_SIZE-1:0]   used_q;
    logic [5:0]             remaining_q;
    logic [5:0]             idx_q;
    logic                   target_q;
    card_t                  new_card_q;
    logic                   add_player_q;
    logic                   add_dealer_q;
    logic                   drop_q;

    logic [5:0]             rand_bits;
    logic [5:0]             start_idx;

    card_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_rand  (rand_bits)
    );

    // Six random bits cover 0..63; fold the top range back into the deck.
    assign start_idx = (rand_bits >= DECK_CNT) ? (rand_bits - DECK_CNT) : rand_bits;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            used_q       <= '0;
            remaining_q  <= DECK_CNT;
            idx_q        <= '0;
            target_q     <= 1'b0;
            new_card_q   <= '0;
            add_player_q <= 1'b0;
            add_dealer_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            add_player_q <= 1'b0;
            add_dealer_q <= 1'b0;
            drop_q       <= 1'b0;
            if (bus.i_shuffle) begin
                // Aborts any draw in flight; a simultaneous request is lost.
                used_q      <= '0;
                remaining_q <= DECK_CNT;
                state_q     <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.i_dealReq) begin
                            if (remaining_q == 6'd0) begin
                                drop_q <= 1'b1;
                            end else begin
                                idx_q    <= start_idx;
                                target_q <= bus.i_dealTarget;
                                state_q  <= PROBE;
                            end
                        end
                    end
                    PROBE: begin
                        if (used_q[idx_q]) begin
                            idx_q <= (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;
                        end else begin
                            used_q[idx_q] <= 1'b1;
                            remaining_q   <= remaining_q - 6'd1;
                            new_card_q    <= card_value(idx_q);
                            add_player_q  <= ~target_q;
                            add_dealer_q  <= target_q;
                            state_q       <= DELIVER;
                        end
                    end
                    DELIVER: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_newCard        = new_card_q;
    assign bus.o_addPlayer      = add_player_q;
    assign bus.o_addDealer      = add_dealer_q;
    assign bus.o_busy           = (state_q != IDLE);
    assign bus.o_cardsRemaining = remaining_q;
    assign bus.o_deckEmpty      = (remaining_q == 6'd0);
    assign bus.o_reqDropped     = drop_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a per-edge reference model (deck as an
// array of dealt flags, delivery scheduled by edge number) is compared against
// the DUT on every falling edge, plus directed checks from the test plan.
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          DECK = 52;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    card_dealer_if bus ();

    card_dealer #(
        .SEED      (SEED),
        .DECK_SIZE (DECK)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    bit          m_used [DECK];
    int          m_rem, m_edge, m_last, m_free_at;
    bit          m_pend, m_pend_tgt;
    int          m_pend_edge, m_pend_val;
    bit          e_player, e_dealer, e_drop;
    int          e_card;

    function automatic int value_of(input int idx);
        int r;
        r = idx % 13;
        if (r == 0) return 1;
        if (r <= 8) return r + 1;
        return 10;
    endfunction

    task automatic model_init();
        m_lfsr = SEED;
        foreach (m_used[i]) m_used[i] = 1'b0;
        m_rem = DECK; m_edge = 0; m_last = 0; m_free_at = 0;
        m_pend = 1'b0; e_player = 1'b0; e_dealer = 1'b0; e_drop = 1'b0; e_card = 0;
    endtask

    task automatic model_edge();
        int idx, skips;
        if (i_reset) begin
            model_init();
            return;
        end
        e_player = 1'b0; e_dealer = 1'b0; e_drop = 1'b0;
        if (m_pend && m_pend_edge == m_edge && !bus.i_shuffle) begin
            e_card   = m_pend_val;
            m_rem    = m_rem - 1;
            e_player = !m_pend_tgt;
            e_dealer = m_pend_tgt;
            m_pend   = 1'b0;
        end
        if (bus.i_shuffle) begin
            foreach (m_used[i]) m_used[i] = 1'b0;
            m_rem = DECK; m_pend = 1'b0; m_free_at = m_edge + 1;
        end else if (bus.i_dealReq && m_edge >= m_free_at) begin
            if (m_rem == 0) begin
                e_drop = 1'b1;
            end else begin
                idx = int'(m_lfsr[5:0]) % DECK;
                skips = 0;
                while (m_used[idx] && skips < DECK) begin
                    idx = (idx + 1) % DECK;
                    skips++;
                end
                m_used[idx] = 1'b1;
                m_pend      = 1'b1;
                m_pend_tgt  = bus.i_dealTarget;
                m_pend_val  = value_of(idx);
                m_pend_edge = m_edge + 1 + skips;
                m_free_at   = m_edge + 3 + skips;
            end
        end
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        m_last = m_edge;
        m_edge++;
    endtask

    always @(posedge i_clk) model_edge();

    // ---------------- per-cycle comparison ----------------
    int n_player = 0;
    int n_dealer = 0;
    int hist [16];

    always @(negedge i_clk) begin
        if (!i_reset) begin
            check_eq("add_player", int'(bus.o_addPlayer), int'(e_player));
            check_eq("add_dealer", int'(bus.o_addDealer), int'(e_dealer));
            check_eq("req_dropped", int'(bus.o_reqDropped), int'(e_drop));
            check_eq("busy", int'(bus.o_busy), int'(m_last < m_free_at - 1));
            check_eq("new_card", int'(bus.o_newCard), e_card);
            check_eq("remaining", int'(bus.o_cardsRemaining), m_rem);
            check_eq("deck_empty", int'(bus.o_deckEmpty), int'(m_rem == 0));
            if (bus.o_addPlayer) n_player++;
            if (bus.o_addDealer) n_dealer++;
            if (bus.o_addPlayer || bus.o_addDealer) hist[bus.o_newCard]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.o_busy && n < 100) begin
            tick();
            n++;
        end
        check_eq("idle_timeout", int'(bus.o_busy), 0);
    endtask

    task automatic deal(input bit tgt);
        wait_idle();
        bus.i_dealReq    = 1'b1;
        bus.i_dealTarget = tgt;
        tick();
        bus.i_dealReq    = 1'b0;
    endtask

    task automatic wait_pulse(input string tag);
        int n = 0;
        while (!(bus.o_addPlayer || bus.o_addDealer) && n < 60) begin
            tick();
            n++;
        end
        check_eq(tag, int'(bus.o_addPlayer || bus.o_addDealer), 1);
    endtask

    initial begin
        foreach (hist[i]) hist[i] = 0;
        bus.i_shuffle = 1'b0; bus.i_dealReq = 1'b0; bus.i_dealTarget = 1'b0;
        repeat (3) tick();

        // First request on the first edge after reset: lfsr = ACE1, idx 33.
        i_reset = 1'b0;
        bus.i_dealReq = 1'b1; bus.i_dealTarget = 1'b0;
        tick();
        bus.i_dealReq = 1'b0;
        check_eq("first_busy", int'(bus.o_busy), 1);
        check_eq("first_no_pulse_early", int'(bus.o_addPlayer), 0);
        tick();
        check_eq("first_player", int'(bus.o_addPlayer), 1);
        check_eq("first_dealer", int'(bus.o_addDealer), 0);
        check_eq("first_card", int'(bus.o_newCard), 8);
        check_eq("first_remaining", int'(bus.o_cardsRemaining), 51);

        // Deal out the rest of the deck, alternating targets.
        for (int k = 1; k < DECK; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            deal(bit'(k % 2));
        end
        wait_idle();
        check_eq("player_pulses", n_player, 26);
        check_eq("dealer_pulses", n_dealer, 26);
        for (int v = 1; v <= 9; v++) check_eq("value_count", hist[v], 4);
        check_eq("ten_count", hist[10], 16);
        check_eq("empty_remaining", int'(bus.o_cardsRemaining), 0);
        check_eq("empty_flag", int'(bus.o_deckEmpty), 1);

        // Request on an empty deck.
        bus.i_dealReq = 1'b1;
        tick();
        bus.i_dealReq = 1'b0;
        check_eq("drop_pulse", int'(bus.o_reqDropped), 1);
        check_eq("drop_busy", int'(bus.o_busy), 0);
        check_eq("drop_no_add", int'(bus.o_addPlayer || bus.o_addDealer), 0);
        tick();
        check_eq("drop_one_cycle", int'(bus.o_reqDropped), 0);

        // Refill, draw a few, then shuffle while a draw is probing.
        bus.i_shuffle = 1'b1; tick(); bus.i_shuffle = 1'b0;
        check_eq("refill_remaining", int'(bus.o_cardsRemaining), 52);
        repeat (5) deal(bit'($urandom_range(0, 1)));
        deal(1'b0);
        check_eq("probe_busy", int'(bus.o_busy), 1);
        bus.i_shuffle = 1'b1; tick(); bus.i_shuffle = 1'b0;
        check_eq("abort_busy", int'(bus.o_busy), 0);
        check_eq("abort_no_add", int'(bus.o_addPlayer || bus.o_addDealer), 0);
        check_eq("abort_remaining", int'(bus.o_cardsRemaining), 52);
        repeat (4) tick();
        deal(1'b1);
        wait_pulse("post_abort_deal");

        // Request together with shuffle is discarded silently.
        wait_idle();
        bus.i_dealReq = 1'b1; bus.i_shuffle = 1'b1;
        tick();
        bus.i_dealReq = 1'b0; bus.i_shuffle = 1'b0;
        check_eq("req_shuffle_busy", int'(bus.o_busy), 0);
        check_eq("req_shuffle_drop", int'(bus.o_reqDropped), 0);

        // Request held high: one card per idle accept.
        bus.i_dealReq = 1'b1;
        repeat (40) begin
            bus.i_dealTarget = 1'($urandom_range(0, 1));
            tick();
        end
        bus.i_dealReq = 1'b0;
        wait_idle();

        // Random traffic with occasional shuffles.
        repeat (400) begin
            bus.i_dealReq    = 1'($urandom_range(0, 1));
            bus.i_dealTarget = 1'($urandom_range(0, 1));
            bus.i_shuffle    = ($urandom_range(0, 31) == 0);
            tick();
        end
        bus.i_dealReq = 1'b0; bus.i_shuffle = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of the DELIVER cycle.
        deal(1'b1);
        wait_pulse("reset_setup_pulse");
        #2 i_reset = 1'b1;
        #1;
        check_eq("rst_add_player", int'(bus.o_addPlayer), 0);
        check_eq("rst_add_dealer", int'(bus.o_addDealer), 0);
        check_eq("rst_new_card", int'(bus.o_newCard), 0);
        check_eq("rst_remaining", int'(bus.o_cardsRemaining), 52);
        check_eq("rst_busy", int'(bus.o_busy), 0);
        tick(); tick();
        i_reset = 1'b0;
        deal(1'b0);
        wait_pulse("post_reset_deal");
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
